// File: rtl/apci_pci_pkg.sv
// Shared types and constants for the AmigaPCI backplane arbiter.
// PARK state exists only when PCI_PARK_ON_HOST_EN is defined.
package apci_pci_pkg;

  localparam int unsigned HOST_MASTER = 0;

  // PCI control lines are active low
  localparam logic ASSERTED_N   = 1'b0;
  localparam logic DEASSERTED_N = 1'b1;

`ifdef PCI_PARK_ON_HOST_EN
  typedef enum logic [2:0] {IDLE, GRANT, BUSY, TURN, PARK} arb_state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT, BUSY, TURN} arb_state_t;
`endif

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin request picker: scans ptr+1, ptr+2, ... with wrap, ptr itself last.
module rr_priority_select #(
  parameter int unsigned NUM_MASTERS = 4,
  localparam int unsigned OW = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [OW-1:0]          ptr,
  output logic [OW-1:0]          winner,
  output logic                   any_req
);

  logic [OW-1:0] idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx = OW'((32'(ptr) + i) % NUM_MASTERS);
      if (!any_req && req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI REQ#/GNT# arbiter with bus-idle tracking, turnaround and grant timeout.
// Define PCI_PARK_ON_HOST_EN to park an idle bus on the bridge host master.
module pci_bus_arbiter
  import apci_pci_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned GNT_TIMEOUT = 16,
  localparam int unsigned OW = $clog2(NUM_MASTERS)
) (
  input  logic                   CLK33,
  input  logic                   RESET,
  input  logic [NUM_MASTERS-1:0] REQn,
  input  logic                   FRAMEn,
  input  logic                   IRDYn,
  output logic [NUM_MASTERS-1:0] GNTn,
  output logic [OW-1:0]          BUS_OWNER,
  output logic                   BUS_IDLE,
  output logic                   TIMEOUT_STB
);

  localparam int unsigned CW = $clog2(GNT_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(GNT_TIMEOUT - 1);
  localparam logic [OW-1:0] HOST_IDX = OW'(HOST_MASTER);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_n_q, gnt_n_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [OW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   bus_idle_q;
  logic                   tstb_q, tstb_d;

  logic [NUM_MASTERS-1:0] req, req_other;
  logic [OW-1:0]          sel_ptr, winner;
  logic                   any_req, bus_idle, take;

  assign req      = ~REQn;
  assign bus_idle = (FRAMEn == DEASSERTED_N) && (IRDYn == DEASSERTED_N);
  // TURN re-arbitrates from the outgoing owner so the next grant needs no extra IDLE clock
  assign sel_ptr  = (state_q == TURN) ? owner_q : ptr_q;

  always_comb begin
    req_other          = req;
    req_other[owner_q] = 1'b0;
  end

  rr_priority_select #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_sel (
    .req    (req),
    .ptr    (sel_ptr),
    .winner (winner),
    .any_req(any_req)
  );

  always_comb begin
    state_d = state_q;
    gnt_n_d = gnt_n_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tstb_d  = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_n_d = '1;
        if (any_req && bus_idle) begin
          take = 1'b1;
`ifdef PCI_PARK_ON_HOST_EN
        end else if (!any_req) begin
          gnt_n_d[HOST_IDX] = ASSERTED_N;
          owner_d           = HOST_IDX;
          state_d           = PARK;
`endif
        end
      end
      GRANT: begin
        if (FRAMEn == ASSERTED_N) begin
          state_d = BUSY;
        end else if (REQn[owner_q] == DEASSERTED_N) begin
          gnt_n_d = '1;
          state_d = TURN;
        end else if (cnt_q == CNT_MAX) begin
          gnt_n_d = '1;
          tstb_d  = 1'b1;
          state_d = TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        // Revoke early so the current owner cannot chain another transaction
        if (|req_other) gnt_n_d = '1;
        if (bus_idle) begin
          if (gnt_n_q[owner_q] == ASSERTED_N && !(|req_other)) begin
            state_d = GRANT;
            cnt_d   = '0;
          end else begin
            gnt_n_d = '1;
            state_d = TURN;
          end
        end
      end
      TURN: begin
        gnt_n_d = '1;
        ptr_d   = owner_q;
        state_d = IDLE;
        if (any_req && bus_idle) take = 1'b1;
      end
`ifdef PCI_PARK_ON_HOST_EN
      PARK: begin
        if (FRAMEn == ASSERTED_N) begin
          state_d = BUSY;
        end else if (|req_other) begin
          gnt_n_d = '1;
          state_d = TURN;
        end else if (REQn[HOST_IDX] == ASSERTED_N) begin
          state_d = GRANT;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        gnt_n_d = '1;
        state_d = IDLE;
      end
    endcase
    if (take) begin
      gnt_n_d         = '1;
      gnt_n_d[winner] = ASSERTED_N;
      owner_d         = winner;
      cnt_d           = '0;
      state_d         = GRANT;
    end
  end

  always_ff @(posedge CLK33) begin
    if (RESET) begin
      state_q    <= IDLE;
      gnt_n_q    <= '1;
      owner_q    <= HOST_IDX;
      ptr_q      <= '0;
      cnt_q      <= '0;
      bus_idle_q <= 1'b0;
      tstb_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_n_q    <= gnt_n_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      bus_idle_q <= bus_idle;
      tstb_q     <= tstb_d;
    end
  end

  assign GNTn        = gnt_n_q;
  assign BUS_OWNER   = owner_q;
  assign BUS_IDLE    = bus_idle_q;
  assign TIMEOUT_STB = tstb_q;

endmodule
